// File: rtl/id_operand_unit_206.sv
// Decode-stage operand unit: register file, MEM/Wr forwarding and stall request.
// Operands and stall are combinational; the array and stall counter are clocked.
module id_operand_unit_206 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Ra_Id,
  input  logic [ADDR_W-1:0] Rb_Id,
  input  logic              UseA_Id,
  input  logic              UseB_Id,
  input  logic              RegWr_Ex,
  input  logic [ADDR_W-1:0] Rw_Ex,
  input  logic              RegWr_Mem,
  input  logic [ADDR_W-1:0] Rw_Mem,
  input  logic              MemRead_Mem,
  input  logic [DATA_W-1:0] ALU_ans_Mem,
  input  logic              RegWr_Wr,
  input  logic [ADDR_W-1:0] Rw_Wr,
  input  logic [DATA_W-1:0] busW_Wr,
  output logic [DATA_W-1:0] busA_Id,
  output logic [DATA_W-1:0] busB_Id,
  output logic              Stall_Id,
  output logic [CNT_W-1:0]  StallCnt,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic [1:0][ADDR_W-1:0] src;
  logic [1:0][DATA_W-1:0] opnd;
  logic [1:0]             hit;
  logic                   stall_raw;

  assign src = {Rb_Id, Ra_Id};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (RegWr_Wr && (Rw_Wr != '0)) begin
      rf_q[Rw_Wr] <= busW_Wr;
    end
  end

  // Priority order: $0, EX hazard, MEM load, MEM forward, Wr bypass, array
  always_comb begin
    opnd = '0;
    hit  = '0;
    for (int s = 0; s < 2; s++) begin
      if (src[s] == '0) begin
        opnd[s] = '0;
      end else if (RegWr_Ex && (Rw_Ex == src[s])) begin
        hit[s] = 1'b1;
      end else if (RegWr_Mem && (Rw_Mem == src[s])) begin
        if (MemRead_Mem) begin
          hit[s] = 1'b1;
        end else begin
          opnd[s] = ALU_ans_Mem;
        end
      end else if (RegWr_Wr && (Rw_Wr == src[s])) begin
        opnd[s] = busW_Wr;
      end else begin
        opnd[s] = rf_q[src[s]];
      end
    end
  end

  assign stall_raw = (UseA_Id & hit[0]) | (UseB_Id & hit[1]);
  assign Stall_Id  = rst_n & stall_raw;

  assign busA_Id = rst_n ? opnd[0] : '0;
  assign busB_Id = rst_n ? opnd[1] : '0;

  always_comb begin
    DbgData = '0;
    if (rst_n && (DbgAddr != '0)) begin
      DbgData = rf_q[DbgAddr];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (Stall_Id && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign StallCnt = cnt_q;

endmodule

// File: tb/tb_id_operand_unit_206.sv
// Bench for id_operand_unit_206: directed vectors, expectations queued and
// checked by a negedge monitor; a second instance with a 4-bit counter.
module tb_id_operand_unit_206;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  Ra, Rb, Rw_Ex, Rw_Mem, Rw_Wr, DbgAddr;
  logic        UseA, UseB, RegWr_Ex, RegWr_Mem, MemRead, RegWr_Wr;
  logic [31:0] ALU, busW;
  logic [31:0] busA, busB, dbg, cnt;
  logic        stall;
  logic [31:0] s_busA, s_busB, s_dbg;
  logic        s_stall;
  logic [3:0]  c4;

  always #5 clk = ~clk;

  id_operand_unit_206 u_dut (
    .clk(clk), .rst_n(rst_n),
    .Ra_Id(Ra), .Rb_Id(Rb), .UseA_Id(UseA), .UseB_Id(UseB),
    .RegWr_Ex(RegWr_Ex), .Rw_Ex(Rw_Ex),
    .RegWr_Mem(RegWr_Mem), .Rw_Mem(Rw_Mem), .MemRead_Mem(MemRead),
    .ALU_ans_Mem(ALU),
    .RegWr_Wr(RegWr_Wr), .Rw_Wr(Rw_Wr), .busW_Wr(busW),
    .busA_Id(busA), .busB_Id(busB), .Stall_Id(stall), .StallCnt(cnt),
    .DbgAddr(DbgAddr), .DbgData(dbg)
  );

  id_operand_unit_206 #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .Ra_Id(Ra), .Rb_Id(Rb), .UseA_Id(UseA), .UseB_Id(UseB),
    .RegWr_Ex(RegWr_Ex), .Rw_Ex(Rw_Ex),
    .RegWr_Mem(RegWr_Mem), .Rw_Mem(Rw_Mem), .MemRead_Mem(MemRead),
    .ALU_ans_Mem(ALU),
    .RegWr_Wr(RegWr_Wr), .Rw_Wr(Rw_Wr), .busW_Wr(busW),
    .busA_Id(s_busA), .busB_Id(s_busB), .Stall_Id(s_stall), .StallCnt(c4),
    .DbgAddr(DbgAddr), .DbgData(s_dbg)
  );

  localparam logic [5:0] MA = 6'b000001;
  localparam logic [5:0] MB = 6'b000010;
  localparam logic [5:0] MS = 6'b000100;
  localparam logic [5:0] MC = 6'b001000;
  localparam logic [5:0] MD = 6'b010000;
  localparam logic [5:0] M4 = 6'b100000;

  typedef struct packed {
    logic [5:0]  m;
    logic [31:0] a;
    logic [31:0] b;
    logic        st;
    logic [31:0] cn;
    logic [31:0] db;
    logic [3:0]  c4;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string nm, input logic [5:0] m,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic st, input logic [31:0] cn,
                     input logic [31:0] db, input logic [3:0] e4);
    exp_t e;
    e.m = m; e.a = a; e.b = b; e.st = st;
    e.cn = cn; e.db = db; e.c4 = e4;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  function automatic void cmp(input string n, input string f,
                              input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s %s got=%h want=%h", n, f, got, want);
    end
  endfunction

  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        if (e.m[0]) cmp(n, "busA", busA, e.a);
        if (e.m[1]) cmp(n, "busB", busB, e.b);
        if (e.m[2]) cmp(n, "stall", {31'd0, stall}, {31'd0, e.st});
        if (e.m[2]) cmp(n, "stall4", {31'd0, s_stall}, {31'd0, e.st});
        if (e.m[3]) cmp(n, "cnt", cnt, e.cn);
        if (e.m[4]) cmp(n, "dbg", dbg, e.db);
        if (e.m[5]) cmp(n, "cnt4", {28'd0, c4}, {28'd0, e.c4});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    Ra = '0; Rb = '0; UseA = 0; UseB = 0;
    RegWr_Ex = 0; Rw_Ex = '0;
    RegWr_Mem = 0; Rw_Mem = '0; MemRead = 0; ALU = '0;
    RegWr_Wr = 0; Rw_Wr = '0; busW = '0; DbgAddr = '0;
  endtask

  initial begin
    idle();
    #1;
    chk("reset", MA|MB|MS|MC|MD|M4, 0, 0, 0, 0, 0, 0);
    step(); step();
    rst_n = 1;

    // write $5, raise a stall, then reset in the middle of it
    RegWr_Wr = 1; Rw_Wr = 5; busW = 32'h1234; Ra = 5; DbgAddr = 5;
    chk("wr5_byp", MA|MD, 32'h1234, 0, 0, 0, 0, 0);
    step();
    RegWr_Wr = 0;
    chk("wr5_arr", MA|MD, 32'h1234, 0, 0, 0, 32'h1234, 0);
    step();
    RegWr_Ex = 1; Rw_Ex = 5; UseA = 1;
    chk("raw_stall", MS|MC, 0, 0, 1, 0, 0, 0);
    step();
    chk("cnt_one", MS|MC|M4, 0, 0, 1, 1, 0, 1);
    @(negedge clk);
    #1;
    rst_n = 0;
    chk("rst_mid", MA|MB|MS|MC|MD|M4, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step();
    rst_n = 1; RegWr_Ex = 0; UseA = 0;
    chk("rst_after", MA|MS|MC|MD, 0, 0, 0, 0, 0, 0);

    // write-first bypass
    step();
    Ra = 7; UseA = 1; RegWr_Wr = 1; Rw_Wr = 7;
    busW = 32'hDEADBEEF; DbgAddr = 7;
    chk("wf_before", MA|MD, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step();
    RegWr_Wr = 0;
    chk("wf_after", MA|MD, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0);

    // $0 never written, never forwarded, never stalls
    step();
    idle();
    RegWr_Wr = 1; Rw_Wr = 0; busW = 32'hFFFFFFFF;
    RegWr_Mem = 1; Rw_Mem = 0; ALU = 32'h5;
    RegWr_Ex = 1; Rw_Ex = 0;
    Ra = 0; Rb = 0; UseA = 1; UseB = 1; DbgAddr = 0;
    chk("r0", MA|MB|MS|MD, 0, 0, 0, 0, 0, 0);
    step();
    idle();
    chk("r0_after", MA|MD, 0, 0, 0, 0, 0, 0);

    // MEM beats Wr for the same register
    step();
    RegWr_Mem = 1; Rw_Mem = 3; ALU = 32'h11;
    RegWr_Wr = 1; Rw_Wr = 3; busW = 32'h22;
    Rb = 3; UseB = 1; Ra = 7; UseA = 1;
    chk("fwd_prio", MA|MB|MS, 32'hDEADBEEF, 32'h11, 0, 0, 0, 0);
    step();
    RegWr_Mem = 0;
    chk("fwd_wr", MB|MS, 0, 32'h22, 0, 0, 0, 0);
    step();
    idle();
    Rb = 3; DbgAddr = 3;
    chk("fwd_arr", MB|MD, 0, 32'h22, 0, 0, 32'h22, 0);

    // load-use: two stall cycles then Wr bypass
    step();
    idle();
    RegWr_Ex = 1; Rw_Ex = 9; Ra = 9; UseA = 1;
    chk("lu_ex", MS|MC, 0, 0, 1, 0, 0, 0);
    step();
    RegWr_Ex = 0; RegWr_Mem = 1; Rw_Mem = 9; MemRead = 1; ALU = 32'hBAD;
    chk("lu_mem", MS|MC, 0, 0, 1, 1, 0, 0);
    step();
    RegWr_Mem = 0; MemRead = 0; RegWr_Wr = 1; Rw_Wr = 9; busW = 32'h9999;
    chk("lu_wr", MA|MS|MC, 32'h9999, 0, 0, 2, 0, 0);
    step();
    idle();
    DbgAddr = 9;
    chk("lu_cnt", MC|MD, 0, 0, 0, 2, 32'h9999, 0);

    // same sequence with the source unused
    step();
    RegWr_Ex = 1; Rw_Ex = 9; Ra = 9; UseA = 0;
    chk("nu_ex", MS, 0, 0, 0, 0, 0, 0);
    step();
    RegWr_Ex = 0; RegWr_Mem = 1; Rw_Mem = 9; MemRead = 1;
    chk("nu_mem", MS, 0, 0, 0, 0, 0, 0);
    step();
    RegWr_Mem = 0; MemRead = 0; RegWr_Wr = 1; Rw_Wr = 9; busW = 32'h7777;
    chk("nu_wr", MA|MS|MC, 32'h7777, 0, 0, 2, 0, 0);

    // ALU producer on B: one stall then MEM forward
    step();
    idle();
    RegWr_Ex = 1; Rw_Ex = 4; Rb = 4; UseB = 1;
    chk("alu_ex", MS|MC, 0, 0, 1, 2, 0, 0);
    step();
    RegWr_Ex = 0; RegWr_Mem = 1; Rw_Mem = 4; ALU = 32'h44;
    chk("alu_mem", MB|MS|MC, 0, 32'h44, 0, 3, 0, 0);
    step();
    idle();
    chk("alu_cnt", MC, 0, 0, 0, 3, 0, 0);

    // saturation of the 4-bit counter
    step();
    rst_n = 0;
    chk("sat_rst", MS|MC|M4, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step();
    rst_n = 1;
    RegWr_Ex = 1; Rw_Ex = 1; Ra = 1; UseA = 1;
    chk("sat_start", MS|MC|M4, 0, 0, 1, 0, 0, 0);
    repeat (20) step();
    chk("sat_20", MS|MC|M4, 0, 0, 1, 20, 0, 15);
    step();
    chk("sat_hold", MC|M4, 0, 0, 0, 21, 0, 15);
    step();
    idle();
    chk("sat_idle", MS|MC|M4, 0, 0, 0, 22, 0, 15);
    step();
    chk("sat_still", MC|M4, 0, 0, 0, 22, 0, 15);

    repeat (3) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
